// File: rtl/alu_cond_stage_if.sv
// alu_cond_stage_if: ALU-side and memory/writeback-side handshake bundle for alu_cond_stage
interface alu_cond_stage_if #(parameter int DW = 32, parameter int RW = 4);
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_res;
  logic [3:0]    in_flags;
  logic [3:0]    in_cond;
  logic [1:0]    in_flag_wr;
  logic          in_reg_wr;
  logic          in_mem_wr;
  logic          in_pc_src;
  logic [RW-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_res;
  logic [RW-1:0] out_rd;
  logic          out_reg_wr;
  logic          out_mem_wr;
  logic          out_pc_src;
  logic [3:0]    nzcv;
  modport master (
    output flush, in_valid, in_res, in_flags, in_cond, in_flag_wr, in_reg_wr, in_mem_wr, in_pc_src, in_rd, out_ready,
    input  in_ready, out_valid, out_res, out_rd, out_reg_wr, out_mem_wr, out_pc_src, nzcv
  );
  modport slave (
    input  flush, in_valid, in_res, in_flags, in_cond, in_flag_wr, in_reg_wr, in_mem_wr, in_pc_src, in_rd, out_ready,
    output in_ready, out_valid, out_res, out_rd, out_reg_wr, out_mem_wr, out_pc_src, nzcv
  );
endinterface

// File: rtl/alu_cond_stage.sv
// alu_cond_stage: NZCV flags register, condition evaluation and one-entry output slot.
// Define COND_SQUASH_CNT_EN to add the saturating squash_cnt output.
module alu_cond_stage #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cond_stage_if.slave   bus
`ifdef COND_SQUASH_CNT_EN
  , output logic [15:0]     squash_cnt
`endif
);
  logic          valid_q, valid_d;
  logic [DW-1:0] res_q, res_d;
  logic [RW-1:0] rd_q, rd_d;
  logic [2:0]    wr_q, wr_d;
  logic [3:0]    nzcv_q, nzcv_d;
  logic          accept, base, cond_ex;
  logic          n, z, c, v;
  assign {n, z, c, v} = nzcv_q;
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  always_comb begin
    // Odd codes below 1110 are the complement of the preceding even code
    base    = bus.in_cond[3:1] == 3'd0 ? z :
              bus.in_cond[3:1] == 3'd1 ? c :
              bus.in_cond[3:1] == 3'd2 ? n :
              bus.in_cond[3:1] == 3'd3 ? v :
              bus.in_cond[3:1] == 3'd4 ? (c && !z) :
              bus.in_cond[3:1] == 3'd5 ? (n == v) :
              bus.in_cond[3:1] == 3'd6 ? (!z && (n == v)) : 1'b1;
    cond_ex = base ^ (bus.in_cond[0] && bus.in_cond[3:1] != 3'b111);
    valid_d = bus.flush ? 1'b0 : accept ? 1'b1 : bus.out_ready ? 1'b0 : valid_q;
    res_d   = accept ? bus.in_res : res_q;
    rd_d    = accept ? bus.in_rd : rd_q;
    wr_d    = accept ? {bus.in_reg_wr, bus.in_mem_wr, bus.in_pc_src} & {3{cond_ex}} : wr_q;
    nzcv_d  = nzcv_q;
    if (accept && cond_ex && bus.in_flag_wr[1]) nzcv_d[3:2] = bus.in_flags[3:2];
    if (accept && cond_ex && bus.in_flag_wr[0]) nzcv_d[1:0] = bus.in_flags[1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      nzcv_q  <= '0;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      nzcv_q  <= nzcv_d;
    end
  end
  assign bus.out_valid  = valid_q;
  assign bus.out_res    = res_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_reg_wr = wr_q[2];
  assign bus.out_mem_wr = wr_q[1];
  assign bus.out_pc_src = wr_q[0];
  assign bus.nzcv       = nzcv_q;
`ifdef COND_SQUASH_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb
    cnt_d = bus.flush ? 16'd0 : (accept && !cond_ex && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign squash_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_alu_cond_stage.sv
// tb_alu_cond_stage: directed and randomized checks of alu_cond_stage against a behavioural model.
module tb_alu_cond_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cmp = 0;
  int   bad = 0;
  alu_cond_stage_if #(.DW(32), .RW(4)) bus ();
`ifdef COND_SQUASH_CNT_EN
  logic [15:0] squash_cnt;
  alu_cond_stage #(.DW(32), .RW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .squash_cnt(squash_cnt));
`else
  alu_cond_stage #(.DW(32), .RW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  logic        m_valid, m_reg, m_mem, m_pc;
  logic [31:0] m_res;
  logic [3:0]  m_rd, m_nzcv;
  logic [15:0] m_cnt;
  logic        obs_rdy, exp_rdy;
  function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] f);
    logic nn, zz, cy, vv;
    {nn, zz, cy, vv} = f;
    case (cc)
      4'h0: return zz;
      4'h1: return !zz;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return nn;
      4'h5: return !nn;
      4'h6: return vv;
      4'h7: return !vv;
      4'h8: return cy && !zz;
      4'h9: return !cy || zz;
      4'hA: return nn == vv;
      4'hB: return nn != vv;
      4'hC: return !zz && (nn == vv);
      4'hD: return zz || (nn != vv);
      default: return 1'b1;
    endcase
  endfunction
  task automatic model_reset();
    m_valid = 0; m_reg = 0; m_mem = 0; m_pc = 0; m_res = 0; m_rd = 0; m_nzcv = 0; m_cnt = 0;
  endtask
  task automatic step(input logic v, input logic [31:0] res, input logic [3:0] flags, input logic [3:0] cond,
                      input logic [1:0] fw, input logic rw, input logic mw, input logic pc,
                      input logic [3:0] rd, input logic ordy, input logic fl);
    logic acc, ex;
    bus.in_valid = v; bus.in_res = res; bus.in_flags = flags; bus.in_cond = cond; bus.in_flag_wr = fw;
    bus.in_reg_wr = rw; bus.in_mem_wr = mw; bus.in_pc_src = pc; bus.in_rd = rd;
    bus.out_ready = ordy; bus.flush = fl;
    #1;
    obs_rdy = bus.in_ready;
    exp_rdy = !m_valid || ordy;
    acc = v && exp_rdy && !fl;
    ex  = cond_model(cond, m_nzcv);
    @(posedge clk);
    if (fl) m_valid = 0;
    else if (acc) begin
      m_valid = 1; m_res = res; m_rd = rd;
      m_reg = rw && ex; m_mem = mw && ex; m_pc = pc && ex;
      if (ex && fw[1]) m_nzcv[3:2] = flags[3:2];
      if (ex && fw[0]) m_nzcv[1:0] = flags[1:0];
    end else if (ordy) m_valid = 0;
    if (fl) m_cnt = 0;
    else if (acc && !ex && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    #1;
  endtask
  task automatic test_reset();
    model_reset();
    rst_n = 0;
    bus.in_valid = 1; bus.in_res = 32'hDEAD_BEEF; bus.in_flags = 4'hF; bus.in_cond = 4'hE; bus.in_flag_wr = 2'b11;
    bus.in_reg_wr = 1; bus.in_mem_wr = 1; bus.in_pc_src = 1; bus.in_rd = 4'h7; bus.out_ready = 1; bus.flush = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp++;
    if ({bus.out_valid, bus.nzcv, bus.out_res, bus.out_rd, bus.out_reg_wr, bus.out_mem_wr, bus.out_pc_src} !== 44'd0) begin
      bad++;
      $display("FAIL reset_state got v=%0b nzcv=%h res=%h rd=%h wr=%b%b%b want all zero", bus.out_valid, bus.nzcv,
               bus.out_res, bus.out_rd, bus.out_reg_wr, bus.out_mem_wr, bus.out_pc_src);
    end
    rst_n = 1;
    step(1, 32'h11, 4'h0, 4'h0, 2'b00, 1, 0, 0, 4'h1, 1, 0);
    cmp++;
    if ({bus.out_valid, bus.out_reg_wr, bus.nzcv} !== {1'b1, 1'b0, 4'h0}) begin
      bad++;
      $display("FAIL eq_after_reset got v=%0b reg_wr=%0b nzcv=%h want v=1 reg_wr=0 nzcv=0", bus.out_valid, bus.out_reg_wr, bus.nzcv);
    end
  endtask
  task automatic test_subs_beq();
    step(1, 32'h0, 4'b0100, 4'hE, 2'b11, 1, 0, 0, 4'h2, 1, 0);
    cmp++;
    if (bus.nzcv !== 4'b0100) begin
      bad++;
      $display("FAIL subs_flags got %b want 0100", bus.nzcv);
    end
    step(1, 32'h40, 4'h0, 4'h0, 2'b00, 0, 0, 1, 4'h0, 1, 0);
    cmp++;
    if ({bus.out_valid, bus.out_pc_src, bus.out_res} !== {1'b1, 1'b1, 32'h40}) begin
      bad++;
      $display("FAIL beq_taken got v=%0b pc=%0b res=%h want v=1 pc=1 res=40", bus.out_valid, bus.out_pc_src, bus.out_res);
    end
  endtask
  task automatic test_lt_ge();
    step(1, 32'h5, 4'b1000, 4'hE, 2'b11, 0, 0, 0, 4'h3, 1, 0);
    step(1, 32'h6, 4'h0, 4'hB, 2'b00, 1, 0, 0, 4'h4, 1, 0);
    cmp++;
    if ({bus.out_reg_wr, bus.nzcv} !== {1'b1, 4'b1000}) begin
      bad++;
      $display("FAIL lt_exec got reg_wr=%0b nzcv=%b want 1 1000", bus.out_reg_wr, bus.nzcv);
    end
    step(1, 32'h7, 4'b0010, 4'hA, 2'b11, 1, 1, 0, 4'h5, 1, 0);
    cmp++;
    if ({bus.out_valid, bus.out_reg_wr, bus.out_mem_wr, bus.nzcv} !== {3'b100, 4'b1000}) begin
      bad++;
      $display("FAIL ge_squash got v=%0b reg_wr=%0b mem_wr=%0b nzcv=%b want 1 0 0 1000", bus.out_valid,
               bus.out_reg_wr, bus.out_mem_wr, bus.nzcv);
    end
  endtask
  task automatic test_flag_wr_cv();
    step(1, 32'h0, 4'h0, 4'hE, 2'b11, 0, 0, 0, 4'h0, 1, 0);
    step(1, 32'h1, 4'hF, 4'hE, 2'b01, 0, 0, 0, 4'h0, 1, 0);
    cmp++;
    if (bus.nzcv !== 4'b0011) begin
      bad++;
      $display("FAIL flag_wr_cv got %b want 0011", bus.nzcv);
    end
  endtask
  task automatic test_stall();
    logic [3:0] nz;
    step(1, 32'hAAAA_0001, 4'h0, 4'hE, 2'b00, 1, 0, 0, 4'h9, 1, 0);
    nz = m_nzcv;
    repeat (3) begin
      step(1, 32'hBBBB_0002, 4'hF, 4'hE, 2'b11, 1, 0, 0, 4'hA, 0, 0);
      cmp++;
      if ({obs_rdy, bus.out_valid, bus.out_res, bus.nzcv} !== {1'b0, 1'b1, 32'hAAAA_0001, nz}) begin
        bad++;
        $display("FAIL stall_hold got rdy=%0b v=%0b res=%h nzcv=%b want 0 1 aaaa0001 %b", obs_rdy, bus.out_valid,
                 bus.out_res, bus.nzcv, nz);
      end
    end
    step(1, 32'hBBBB_0002, 4'hF, 4'hE, 2'b11, 1, 0, 0, 4'hA, 1, 0);
    cmp++;
    if ({obs_rdy, bus.out_valid, bus.out_res, bus.out_rd, bus.nzcv} !== {1'b1, 1'b1, 32'hBBBB_0002, 4'hA, 4'hF}) begin
      bad++;
      $display("FAIL stall_release got rdy=%0b v=%0b res=%h rd=%h nzcv=%b want 1 1 bbbb0002 a 1111", obs_rdy,
               bus.out_valid, bus.out_res, bus.out_rd, bus.nzcv);
    end
  endtask
  task automatic test_flush();
    step(1, 32'hC, 4'h0, 4'hE, 2'b11, 1, 1, 1, 4'hC, 0, 1);
    cmp++;
    if ({bus.out_valid, bus.nzcv} !== {1'b0, 4'hF}) begin
      bad++;
      $display("FAIL flush_stalled got v=%0b nzcv=%b want 0 1111", bus.out_valid, bus.nzcv);
    end
    step(1, 32'hD, 4'h0, 4'hE, 2'b11, 1, 1, 1, 4'hD, 1, 1);
    cmp++;
    if ({obs_rdy, bus.out_valid, bus.nzcv, bus.out_res} !== {1'b1, 1'b0, 4'hF, 32'hBBBB_0002}) begin
      bad++;
      $display("FAIL flush_drop got rdy=%0b v=%0b nzcv=%b res=%h want 1 0 1111 bbbb0002", obs_rdy, bus.out_valid,
               bus.nzcv, bus.out_res);
    end
  endtask
`ifdef COND_SQUASH_CNT_EN
  task automatic test_squash_cnt();
    step(1, 32'h0, 4'h0, 4'hE, 2'b11, 0, 0, 0, 4'h0, 1, 1);
    step(1, 32'h0, 4'h0, 4'hE, 2'b11, 0, 0, 0, 4'h0, 1, 0);
    repeat (3) step(1, 32'h1, 4'h0, 4'h0, 2'b00, 1, 0, 0, 4'h1, 1, 0);
    cmp++;
    if (squash_cnt !== 16'd3) begin
      bad++;
      $display("FAIL squash_cnt3 got %0d want 3", squash_cnt);
    end
    step(0, 32'h0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 4'h0, 1, 1);
    cmp++;
    if (squash_cnt !== 16'd0) begin
      bad++;
      $display("FAIL squash_cnt_flush got %0d want 0", squash_cnt);
    end
  endtask
`endif
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, 4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      cmp++;
      if (obs_rdy !== exp_rdy) begin
        bad++;
        $display("FAIL rnd_in_ready cyc %0d got %0b want %0b", i, obs_rdy, exp_rdy);
      end
      cmp++;
      if ({bus.out_valid, bus.nzcv, bus.out_res, bus.out_rd, bus.out_reg_wr, bus.out_mem_wr, bus.out_pc_src} !==
          {m_valid, m_nzcv, m_res, m_rd, m_reg, m_mem, m_pc}) begin
        bad++;
        $display("FAIL rnd_out cyc %0d got v=%0b nzcv=%b res=%h rd=%h wr=%b%b%b want v=%0b nzcv=%b res=%h rd=%h wr=%b%b%b",
                 i, bus.out_valid, bus.nzcv, bus.out_res, bus.out_rd, bus.out_reg_wr, bus.out_mem_wr, bus.out_pc_src,
                 m_valid, m_nzcv, m_res, m_rd, m_reg, m_mem, m_pc);
      end
`ifdef COND_SQUASH_CNT_EN
      cmp++;
      if (squash_cnt !== m_cnt) begin
        bad++;
        $display("FAIL rnd_squash_cnt cyc %0d got %0d want %0d", i, squash_cnt, m_cnt);
      end
`endif
    end
  endtask
  task automatic test_reset_mid();
    step(1, 32'h1234_5678, 4'hF, 4'hE, 2'b11, 1, 1, 1, 4'hE, 0, 0);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    cmp++;
    if ({bus.out_valid, bus.nzcv, bus.out_res, bus.out_reg_wr} !== 38'd0) begin
      bad++;
      $display("FAIL reset_mid got v=%0b nzcv=%b res=%h reg_wr=%0b want all zero", bus.out_valid, bus.nzcv,
               bus.out_res, bus.out_reg_wr);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    step(1, 32'h9, 4'h0, 4'hE, 2'b00, 1, 0, 0, 4'h9, 1, 0);
    cmp++;
    if ({bus.out_valid, bus.out_reg_wr, bus.out_res} !== {1'b1, 1'b1, 32'h9}) begin
      bad++;
      $display("FAIL after_reset_mid got v=%0b reg_wr=%0b res=%h want 1 1 9", bus.out_valid, bus.out_reg_wr, bus.out_res);
    end
  endtask
  initial begin
    test_reset();
    test_subs_beq();
    test_lt_ge();
    test_flag_wr_cv();
    test_stall();
    test_flush();
`ifdef COND_SQUASH_CNT_EN
    test_squash_cnt();
`endif
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
